// File: rtl/host_cmd_parser.sv
// host_cmd_parser: host command packet receiver with header extraction, payload pass-through and checksum check.
// Define HOST_CMD_TIMEOUT_EN to abort packets that stall for timeout_cycles outside DEST.
module host_cmd_parser #(
    parameter int host_width     = 16,
    parameter int timeout_cycles = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [host_width-1:0] in_data,
    input  logic                  in_enable,
    output logic                  in_ready,
    output logic                  hdr_valid,
    output logic [7:0]            hdr_dest,
    output logic [7:0]            hdr_cmd,
    output logic [23:0]           hdr_length,
    output logic [host_width-1:0] out_data,
    output logic                  out_enable,
    input  logic                  out_ready,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic [1:0]            err_code,
    output logic [15:0]           err_count
);
    typedef enum logic [2:0] {
        S_DEST, S_CMD, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM_HI, S_CSUM_LO
    } state_t;

    state_t      state_q;
    logic [7:0]  hdr_dest_q, hdr_cmd_q;
    logic [23:0] hdr_length_q, rem_q, length_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] csum_hi_q, err_count_q, err_count_d;
    logic        hdr_valid_q, pkt_done_q, pkt_ok_q, match_d, xfer;
    logic [1:0]  err_code_q;
`ifdef HOST_CMD_TIMEOUT_EN
    logic [15:0] idle_q;
`endif

    assign xfer        = in_enable && in_ready;
    assign in_ready    = (state_q == S_DATA) ? out_ready : 1'b1;
    assign out_enable  = (state_q == S_DATA) && in_enable;
    assign out_data    = in_data;
    assign length_d    = {hdr_length_q[23:16], in_data[15:0]};
    assign acc_d       = acc_q + {16'h0, in_data[15:0]};
    assign match_d     = {csum_hi_q, in_data[15:0]} == acc_q;
    assign err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

    assign hdr_valid  = hdr_valid_q;
    assign hdr_dest   = hdr_dest_q;
    assign hdr_cmd    = hdr_cmd_q;
    assign hdr_length = hdr_length_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_ok     = pkt_ok_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_DEST;
            hdr_dest_q   <= '0;
            hdr_cmd_q    <= '0;
            hdr_length_q <= '0;
            rem_q        <= '0;
            acc_q        <= '0;
            csum_hi_q    <= '0;
            hdr_valid_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_ok_q     <= 1'b0;
            err_code_q   <= 2'd0;
            err_count_q  <= '0;
`ifdef HOST_CMD_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            hdr_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            if (xfer) begin
                case (state_q)
                    S_DEST: begin
                        hdr_dest_q <= in_data[7:0];
                        state_q    <= S_CMD;
                    end
                    S_CMD: begin
                        hdr_cmd_q <= in_data[7:0];
                        state_q   <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        hdr_length_q[23:16] <= in_data[7:0];
                        state_q             <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        hdr_length_q[15:0] <= in_data[15:0];
                        rem_q              <= length_d;
                        acc_q              <= '0;
                        hdr_valid_q        <= 1'b1;
                        state_q            <= (length_d == 24'd0) ? S_CSUM_HI : S_DATA;
                    end
                    S_DATA: begin
                        acc_q   <= acc_d;
                        rem_q   <= rem_q - 24'd1;
                        state_q <= (rem_q == 24'd1) ? S_CSUM_HI : S_DATA;
                    end
                    S_CSUM_HI: begin
                        csum_hi_q <= in_data[15:0];
                        state_q   <= S_CSUM_LO;
                    end
                    S_CSUM_LO: begin
                        pkt_done_q  <= 1'b1;
                        pkt_ok_q    <= match_d;
                        err_code_q  <= match_d ? 2'd0 : 2'd1;
                        err_count_q <= match_d ? err_count_q : err_count_d;
                        state_q     <= S_DEST;
                    end
                    default: state_q <= S_DEST;
                endcase
            end
`ifdef HOST_CMD_TIMEOUT_EN
            // Stalls count too, so a blocked downstream eventually frees the parser.
            if (xfer || state_q == S_DEST) begin
                idle_q <= '0;
            end else if (idle_q == 16'(timeout_cycles - 1)) begin
                idle_q      <= '0;
                state_q     <= S_DEST;
                pkt_done_q  <= 1'b1;
                pkt_ok_q    <= 1'b0;
                err_code_q  <= 2'd2;
                err_count_q <= err_count_d;
            end else begin
                idle_q <= idle_q + 16'd1;
            end
`endif
        end
    end
endmodule
